// File: rtl/cpu_6502.sv
// Reduced 6502-compatible 8-bit CPU core: shared 16-bit address bus, separate read/write data buses,
// one instruction at a time through a FETCH/OPLO/OPHI/MEM/BRANCH state machine starting at 0x8000.
module cpu_6502 (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  din,
    input  logic        irq,
    input  logic        nmi,
    input  logic        rdy,
    output logic        we,
    output logic [15:0] adr,
    output logic [7:0]  dout
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        OPLO   = 3'd1,
        OPHI   = 3'd2,
        MEM    = 3'd3,
        BRANCH = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic [7:0]  s_q, s_d;
    logic [7:0]  p_q, p_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] ea_q, ea_d;

    logic [15:0] adr_s;
    logic        we_s;
    logic [7:0]  dout_s;
    logic [15:0] pc_inc_s;
    logic [15:0] br_target_s;
    logic [15:0] idx_s;
    logic [7:0]  x_inc_s, x_dec_s, y_inc_s, y_dec_s;
    logic        unused_s;

    function automatic logic [7:0] set_nz(input logic [7:0] p, input logic [7:0] v);
        return {v[7], p[6:2], (v == 8'h00), p[0]};
    endfunction

    // N and Z come from the 8-bit difference, C is an unsigned no-borrow flag
    function automatic logic [7:0] cmp_flags(input logic [7:0] p, input logic [7:0] r, input logic [7:0] o);
        logic [7:0] diff;
        diff = r - o;
        return {diff[7], p[6:2], (diff == 8'h00), (r >= o)};
    endfunction

    function automatic logic branch_taken(input logic [7:0] op, input logic [7:0] p);
        logic t;
        case (op)
            8'hD0:   t = ~p[1];
            8'hF0:   t = p[1];
            8'h10:   t = ~p[7];
            8'h30:   t = p[7];
            8'h90:   t = ~p[0];
            8'hB0:   t = p[0];
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    assign pc_inc_s    = pc_q + 16'd1;
    assign br_target_s = pc_q + {{8{lo_q[7]}}, lo_q};
    assign idx_s       = (opcode_q == 8'hB9) ? {8'h00, y_q} :
                         ((opcode_q == 8'hBD) || (opcode_q == 8'h9D)) ? {8'h00, x_q} : 16'h0000;
    assign x_inc_s     = x_q + 8'd1;
    assign x_dec_s     = x_q - 8'd1;
    assign y_inc_s     = y_q + 8'd1;
    assign y_dec_s     = y_q - 8'd1;
    assign unused_s    = ^{irq, nmi, rdy};

    assign adr  = adr_s;
    assign we   = we_s;
    assign dout = dout_s;

    // Next-state, register-update and bus-drive logic for every instruction cycle
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        a_d      = a_q;
        x_d      = x_q;
        y_d      = y_q;
        s_d      = s_q;
        p_d      = p_q;
        opcode_d = opcode_q;
        lo_d     = lo_q;
        ea_d     = ea_q;
        adr_s    = pc_q;
        we_s     = 1'b0;
        dout_s   = 8'h00;
        case (state_q)
            FETCH: begin
                opcode_d = din;
                pc_d     = pc_inc_s;
                state_d  = OPLO;
            end
            OPLO: begin
                state_d = FETCH;
                case (opcode_q)
                    8'hA9: begin a_d = din; p_d = set_nz(p_q, din); pc_d = pc_inc_s; end
                    8'hA2: begin x_d = din; p_d = set_nz(p_q, din); pc_d = pc_inc_s; end
                    8'hA0: begin y_d = din; p_d = set_nz(p_q, din); pc_d = pc_inc_s; end
                    8'hC9: begin p_d = cmp_flags(p_q, a_q, din); pc_d = pc_inc_s; end
                    8'hE0: begin p_d = cmp_flags(p_q, x_q, din); pc_d = pc_inc_s; end
                    8'hC0: begin p_d = cmp_flags(p_q, y_q, din); pc_d = pc_inc_s; end
                    8'hA5, 8'hA6, 8'hA4, 8'h85, 8'h86, 8'h84: begin
                        ea_d    = {8'h00, din};
                        pc_d    = pc_inc_s;
                        state_d = MEM;
                    end
                    8'hAD, 8'hAE, 8'hAC, 8'hBD, 8'hB9, 8'h8D, 8'h8E, 8'h8C, 8'h9D, 8'h4C: begin
                        lo_d    = din;
                        pc_d    = pc_inc_s;
                        state_d = OPHI;
                    end
                    8'hD0, 8'hF0, 8'h10, 8'h30, 8'h90, 8'hB0: begin
                        lo_d    = din;
                        pc_d    = pc_inc_s;
                        state_d = branch_taken(opcode_q, p_q) ? BRANCH : FETCH;
                    end
                    8'hE8: begin x_d = x_inc_s; p_d = set_nz(p_q, x_inc_s); end
                    8'hC8: begin y_d = y_inc_s; p_d = set_nz(p_q, y_inc_s); end
                    8'hCA: begin x_d = x_dec_s; p_d = set_nz(p_q, x_dec_s); end
                    8'h88: begin y_d = y_dec_s; p_d = set_nz(p_q, y_dec_s); end
                    8'hAA: begin x_d = a_q; p_d = set_nz(p_q, a_q); end
                    8'h8A: begin a_d = x_q; p_d = set_nz(p_q, x_q); end
                    8'hA8: begin y_d = a_q; p_d = set_nz(p_q, a_q); end
                    8'h98: begin a_d = y_q; p_d = set_nz(p_q, y_q); end
                    8'h9A: s_d = x_q;
                    8'hBA: begin x_d = s_q; p_d = set_nz(p_q, s_q); end
                    8'h18: p_d = {p_q[7:1], 1'b0};
                    8'h38: p_d = {p_q[7:1], 1'b1};
                    8'h58: p_d = {p_q[7:3], 1'b0, p_q[1:0]};
                    8'h78: p_d = {p_q[7:3], 1'b1, p_q[1:0]};
                    default: state_d = FETCH;
                endcase
            end
            OPHI: begin
                if (opcode_q == 8'h4C) begin
                    pc_d    = {din, lo_q};
                    state_d = FETCH;
                end else begin
                    pc_d    = pc_inc_s;
                    ea_d    = {din, lo_q} + idx_s;
                    state_d = MEM;
                end
            end
            MEM: begin
                adr_s   = ea_q;
                state_d = FETCH;
                case (opcode_q)
                    8'hA5, 8'hAD, 8'hBD, 8'hB9: begin a_d = din; p_d = set_nz(p_q, din); end
                    8'hA6, 8'hAE:               begin x_d = din; p_d = set_nz(p_q, din); end
                    8'hA4, 8'hAC:               begin y_d = din; p_d = set_nz(p_q, din); end
                    8'h85, 8'h8D, 8'h9D:        begin we_s = 1'b1; dout_s = a_q; end
                    8'h86, 8'h8E:               begin we_s = 1'b1; dout_s = x_q; end
                    8'h84, 8'h8C:               begin we_s = 1'b1; dout_s = y_q; end
                    default:                    state_d = FETCH;
                endcase
            end
            BRANCH: begin
                pc_d    = br_target_s;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Architectural and sequencing state, forced to power-on values while reset is low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= FETCH;
            pc_q     <= 16'h8000;
            a_q      <= 8'h00;
            x_q      <= 8'h00;
            y_q      <= 8'h00;
            s_q      <= 8'hFF;
            p_q      <= 8'h24;
            opcode_q <= 8'hEA;
            lo_q     <= 8'h00;
            ea_q     <= 16'h0000;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            a_q      <= a_d;
            x_q      <= x_d;
            y_q      <= y_d;
            s_q      <= s_d;
            p_q      <= p_d;
            opcode_q <= opcode_d;
            lo_q     <= lo_d;
            ea_q     <= ea_d;
        end
    end

endmodule

// File: tb/tb_cpu_6502.sv
// Self-checking bench for cpu_6502: directed program scenarios plus random programs run in
// lockstep with an instruction-level reference model that predicts every bus cycle.
module tb_cpu_6502;

    logic        clk;
    logic        reset;
    logic [7:0]  din;
    logic        irq, nmi, rdy;
    logic        we;
    logic [15:0] adr;
    logic [7:0]  dout;

    logic [7:0]  mem [0:65535];
    logic [7:0]  m   [0:65535];
    int          n_tests;
    int          n_fail;

    // reference model state and predicted bus trace
    logic [7:0]  ma, mx, my, ms, mp;
    logic [15:0] mpc;
    logic [15:0] qa [$];
    logic        qw [$];
    logic [7:0]  qd [$];

    logic [7:0] op_tab [43] = '{
        8'hA9, 8'hA2, 8'hA0, 8'hA5, 8'hA6, 8'hA4, 8'hAD, 8'hAE, 8'hAC, 8'hBD, 8'hB9,
        8'h85, 8'h86, 8'h84, 8'h8D, 8'h8E, 8'h8C, 8'h9D,
        8'hE8, 8'hC8, 8'hCA, 8'h88, 8'hAA, 8'h8A, 8'hA8, 8'h98, 8'h9A, 8'hBA,
        8'h18, 8'h38, 8'h58, 8'h78, 8'hC9, 8'hE0, 8'hC0,
        8'hD0, 8'hF0, 8'h10, 8'h30, 8'h90, 8'hB0, 8'h4C, 8'hEA};

    assign din = mem[adr];

    cpu_6502 dut (
        .clk(clk), .reset(reset), .din(din), .irq(irq), .nmi(nmi), .rdy(rdy),
        .we(we), .adr(adr), .dout(dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // memory commits a store during its write cycle, then one full clock elapses
    task automatic tick();
        if (we === 1'b1) mem[adr] = dout;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic bus(input logic [15:0] a, input logic w, input logic [7:0] d);
        qa.push_back(a);
        qw.push_back(w);
        qd.push_back(d);
    endtask

    function automatic logic [7:0] nzf(input logic [7:0] p, input logic [7:0] v);
        logic [7:0] r;
        r    = p;
        r[7] = v[7];
        r[1] = (v == 8'h00);
        return r;
    endfunction

    function automatic logic [7:0] cmpf(input logic [7:0] p, input logic [7:0] r, input logic [7:0] o);
        int d;
        logic [7:0] q;
        d    = int'(r) - int'(o);
        q    = p;
        q[0] = (d >= 0);
        q[1] = (d == 0);
        q[7] = (d < 0) ? ((d + 256) >= 128) : (d >= 128);
        return q;
    endfunction

    // executes one whole instruction and queues the bus cycles it must produce
    task automatic model_step();
        logic [7:0]  op, v, lo, hi, off;
        logic [15:0] ea;
        logic        taken;
        v = 8'h00; lo = 8'h00; hi = 8'h00; ea = 16'h0000;
        op = m[mpc]; bus(mpc, 1'b0, 8'h00); mpc = mpc + 16'd1;
        case (op)
            8'hA9, 8'hA2, 8'hA0, 8'hC9, 8'hE0, 8'hC0: begin
                bus(mpc, 1'b0, 8'h00); v = m[mpc]; mpc = mpc + 16'd1;
            end
            8'hA5, 8'hA6, 8'hA4, 8'h85, 8'h86, 8'h84: begin
                bus(mpc, 1'b0, 8'h00); ea = {8'h00, m[mpc]}; mpc = mpc + 16'd1;
            end
            8'hAD, 8'hAE, 8'hAC, 8'hBD, 8'hB9, 8'h8D, 8'h8E, 8'h8C, 8'h9D, 8'h4C: begin
                bus(mpc, 1'b0, 8'h00); lo = m[mpc]; mpc = mpc + 16'd1;
                bus(mpc, 1'b0, 8'h00); hi = m[mpc];
                if (op != 8'h4C) mpc = mpc + 16'd1;
                ea = {hi, lo};
                if (op == 8'hBD || op == 8'h9D) ea = ea + {8'h00, mx};
                if (op == 8'hB9) ea = ea + {8'h00, my};
            end
            8'hD0, 8'hF0, 8'h10, 8'h30, 8'h90, 8'hB0: begin
                bus(mpc, 1'b0, 8'h00); off = m[mpc]; mpc = mpc + 16'd1;
                case (op)
                    8'hD0:   taken = !mp[1];
                    8'hF0:   taken = mp[1];
                    8'h10:   taken = !mp[7];
                    8'h30:   taken = mp[7];
                    8'h90:   taken = !mp[0];
                    default: taken = mp[0];
                endcase
                if (taken) begin
                    bus(mpc, 1'b0, 8'h00);
                    mpc = 16'(int'(mpc) + int'($signed(off)));
                end
            end
            default: bus(mpc, 1'b0, 8'h00);
        endcase
        case (op)
            8'hA9: begin ma = v; mp = nzf(mp, ma); end
            8'hA2: begin mx = v; mp = nzf(mp, mx); end
            8'hA0: begin my = v; mp = nzf(mp, my); end
            8'hA5, 8'hAD, 8'hBD, 8'hB9: begin bus(ea, 1'b0, 8'h00); ma = m[ea]; mp = nzf(mp, ma); end
            8'hA6, 8'hAE: begin bus(ea, 1'b0, 8'h00); mx = m[ea]; mp = nzf(mp, mx); end
            8'hA4, 8'hAC: begin bus(ea, 1'b0, 8'h00); my = m[ea]; mp = nzf(mp, my); end
            8'h85, 8'h8D, 8'h9D: begin bus(ea, 1'b1, ma); m[ea] = ma; end
            8'h86, 8'h8E: begin bus(ea, 1'b1, mx); m[ea] = mx; end
            8'h84, 8'h8C: begin bus(ea, 1'b1, my); m[ea] = my; end
            8'hC9: mp = cmpf(mp, ma, v);
            8'hE0: mp = cmpf(mp, mx, v);
            8'hC0: mp = cmpf(mp, my, v);
            8'h4C: mpc = {hi, lo};
            8'hE8: begin mx = mx + 8'd1; mp = nzf(mp, mx); end
            8'hC8: begin my = my + 8'd1; mp = nzf(mp, my); end
            8'hCA: begin mx = mx - 8'd1; mp = nzf(mp, mx); end
            8'h88: begin my = my - 8'd1; mp = nzf(mp, my); end
            8'hAA: begin mx = ma; mp = nzf(mp, mx); end
            8'h8A: begin ma = mx; mp = nzf(mp, ma); end
            8'hA8: begin my = ma; mp = nzf(mp, my); end
            8'h98: begin ma = my; mp = nzf(mp, ma); end
            8'h9A: ms = mx;
            8'hBA: begin mx = ms; mp = nzf(mp, mx); end
            8'h18: mp[0] = 1'b0;
            8'h38: mp[0] = 1'b1;
            8'h58: mp[2] = 1'b0;
            8'h78: mp[2] = 1'b1;
            default: ;
        endcase
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_mem();
        #1 reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (adr !== 16'h8000 || we !== 1'b0 || dout !== 8'h00) begin
            n_fail++; $display("FAIL reset_outputs: got adr=%h we=%b dout=%h, want 8000 0 00", adr, we, dout);
        end
        n_tests++;
        if ({dut.a_q, dut.x_q, dut.y_q, dut.s_q, dut.p_q} !== 40'h00_00_00_FF_24) begin
            n_fail++; $display("FAIL reset_regs: got %h, want 000000ff24", {dut.a_q, dut.x_q, dut.y_q, dut.s_q, dut.p_q});
        end
        @(posedge clk); @(negedge clk);
        n_tests++;
        if (adr !== 16'h8000 || we !== 1'b0) begin
            n_fail++; $display("FAIL reset_hold: got adr=%h we=%b, want 8000 0", adr, we);
        end
        reset = 1'b1;
        n_tests++;
        if (adr !== 16'h8000) begin n_fail++; $display("FAIL first_fetch: got %h, want 8000", adr); end
        tick();
        n_tests++;
        if (adr !== 16'h8001) begin n_fail++; $display("FAIL nop_dummy: got %h, want 8001", adr); end
        tick();
        n_tests++;
        if (adr !== 16'h8001) begin n_fail++; $display("FAIL second_fetch: got %h, want 8001", adr); end
    endtask

    task automatic test_init_seq();
        logic [7:0] prog [12] = '{8'h78, 8'hA2, 8'hFF, 8'h9A, 8'hA9, 8'h00, 8'h8D, 8'h00, 8'h20, 8'h4C, 8'h09, 8'h80};
        int we_cyc, we_cnt;
        logic [15:0] we_adr;
        logic [7:0]  we_dout, s7, p7;
        clear_mem();
        for (int i = 0; i < 12; i++) mem[16'h8000 + i] = prog[i];
        do_reset();
        we_cyc = 0; we_cnt = 0; we_adr = 16'h0000; we_dout = 8'hFF; s7 = 8'h00; p7 = 8'h00;
        for (int cyc = 1; cyc <= 24; cyc++) begin
            if (we === 1'b1) begin
                we_cnt++;
                if (we_cyc == 0) begin we_cyc = cyc; we_adr = adr; we_dout = dout; end
            end
            if (cyc == 7) begin s7 = dut.s_q; p7 = dut.p_q; end
            tick();
        end
        n_tests++;
        if (s7 !== 8'hFF || p7[2] !== 1'b1) begin
            n_fail++; $display("FAIL init_txs: got S=%h P=%h, want S=ff I=1", s7, p7);
        end
        n_tests++;
        if (we_cyc != 12 || we_cnt != 1) begin
            n_fail++; $display("FAIL init_we_timing: got cycle %0d count %0d, want cycle 12 count 1", we_cyc, we_cnt);
        end
        n_tests++;
        if (we_adr !== 16'h2000 || we_dout !== 8'h00 || mem[16'h2000] !== 8'h00) begin
            n_fail++; $display("FAIL init_store: got adr=%h dout=%h, want 2000 00", we_adr, we_dout);
        end
    endtask

    task automatic test_copy_loop();
        logic [7:0] prog [17] = '{8'hA2, 8'h00, 8'hA0, 8'h10, 8'hBD, 8'h51, 8'h80, 8'h8D, 8'h07, 8'h20,
                                  8'hE8, 8'h88, 8'hD0, 8'hF6, 8'h4C, 8'h0E, 8'h80};
        logic [7:0] tab [16] = '{8'h0F, 8'h00, 8'h10, 8'h20, 8'h0F, 8'h06, 8'h16, 8'h26,
                                 8'h0F, 8'h08, 8'h18, 8'h28, 8'h0F, 8'h0A, 8'h1A, 8'h2A};
        logic [7:0] got [$];
        int other;
        clear_mem();
        for (int i = 0; i < 17; i++) mem[16'h8000 + i] = prog[i];
        for (int i = 0; i < 16; i++) mem[16'h8051 + i] = tab[i];
        do_reset();
        other = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (we === 1'b1) begin
                if (adr === 16'h2007) got.push_back(dout);
                else other++;
            end
            tick();
        end
        n_tests++;
        if (got.size() != 16 || other != 0) begin
            n_fail++; $display("FAIL copy_count: got %0d writes (%0d stray), want 16", got.size(), other);
        end
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            n_tests++;
            if (got[i] !== tab[i]) begin
                n_fail++; $display("FAIL copy_byte[%0d]: got %h, want %h", i, got[i], tab[i]);
            end
        end
        n_tests++;
        if (dut.y_q !== 8'h00 || dut.p_q[1] !== 1'b1 || dut.x_q !== 8'h10) begin
            n_fail++; $display("FAIL copy_exit: got Y=%h Z=%b X=%h, want 00 1 10", dut.y_q, dut.p_q[1], dut.x_q);
        end
    endtask

    task automatic test_terminal_loop();
        int k;
        logic [15:0] exp_adr;
        clear_mem();
        mem[16'h8000] = 8'h4C; mem[16'h8001] = 8'h4E; mem[16'h8002] = 8'h80;
        mem[16'h804E] = 8'h4C; mem[16'h804F] = 8'h4E; mem[16'h8050] = 8'h80;
        do_reset();
        k = 0;
        while (adr !== 16'h804E && k < 20) begin tick(); k++; end
        n_tests++;
        if (adr !== 16'h804E) begin n_fail++; $display("FAIL loop_reach: got %h, want 804e", adr); end
        for (int i = 0; i < 12; i++) begin
            exp_adr = 16'h804E + 16'(i % 3);
            n_tests++;
            if (adr !== exp_adr || we !== 1'b0) begin
                n_fail++; $display("FAIL loop_cycle[%0d]: got adr=%h we=%b, want %h 0", i, adr, we, exp_adr);
            end
            tick();
        end
    endtask

    task automatic test_compare_branch();
        logic [7:0]  prog [13] = '{8'hA9, 8'h05, 8'hC9, 8'h06, 8'h90, 8'h02, 8'hEA, 8'hEA,
                                   8'hB0, 8'h02, 8'h4C, 8'h0A, 8'h80};
        logic [15:0] rec_adr [1:14];
        logic [7:0]  rec_p   [1:14];
        int c1, c2, c3;
        clear_mem();
        for (int i = 0; i < 13; i++) mem[16'h8000 + i] = prog[i];
        do_reset();
        for (int cyc = 1; cyc <= 14; cyc++) begin
            rec_adr[cyc] = adr; rec_p[cyc] = dut.p_q;
            tick();
        end
        c1 = 0; c2 = 0; c3 = 0;
        for (int cyc = 14; cyc >= 1; cyc--) begin
            if (rec_adr[cyc] === 16'h8004) c1 = cyc;
            if (rec_adr[cyc] === 16'h8008) c2 = cyc;
            if (rec_adr[cyc] === 16'h800A) c3 = cyc;
        end
        n_tests++;
        if (c1 != 5) begin n_fail++; $display("FAIL bcc_fetch_cycle: got %0d, want 5", c1); end
        n_tests++;
        if (rec_p[5][0] !== 1'b0 || rec_p[5][7] !== 1'b1 || rec_p[5][1] !== 1'b0) begin
            n_fail++; $display("FAIL cmp_flags: got P=%h, want C=0 N=1 Z=0", rec_p[5]);
        end
        n_tests++;
        if (c2 - c1 != 3 || rec_adr[7] !== 16'h8006) begin
            n_fail++; $display("FAIL bcc_taken: got %0d cycles dummy=%h, want 3 8006", c2 - c1, rec_adr[7]);
        end
        n_tests++;
        if (c3 - c2 != 2) begin n_fail++; $display("FAIL bcs_not_taken: got %0d cycles, want 2", c3 - c2); end
        n_tests++;
        if (dut.a_q !== 8'h05) begin n_fail++; $display("FAIL cmp_keeps_a: got %h, want 05", dut.a_q); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        clear_mem();
        mem[16'h8000] = 8'h8D; mem[16'h8001] = 8'h00; mem[16'h8002] = 8'h20;
        mem[16'h2000] = 8'h5A;
        do_reset();
        pulses = 0;
        tick();
        tick();
        n_tests++;
        if (adr !== 16'h8002) begin n_fail++; $display("FAIL mid_cycle3: got %h, want 8002", adr); end
        #1 reset = 1'b0;
        #1;
        n_tests++;
        if (adr !== 16'h8000 || we !== 1'b0) begin
            n_fail++; $display("FAIL mid_async: got adr=%h we=%b, want 8000 0", adr, we);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (we === 1'b1) pulses++;
        end
        @(negedge clk);
        reset = 1'b1;
        n_tests++;
        if (pulses != 0 || mem[16'h2000] !== 8'h5A || adr !== 16'h8000) begin
            n_fail++; $display("FAIL mid_no_store: got pulses=%0d mem=%h adr=%h, want 0 5a 8000", pulses, mem[16'h2000], adr);
        end
    endtask

    task automatic test_random();
        logic [7:0]  b;
        logic [15:0] ea;
        logic        ew, bad;
        logic [7:0]  ed;
        for (int round = 0; round < 4; round++) begin
            for (int i = 0; i < 65536; i++) begin
                if ($urandom_range(0, 9) < 7) b = op_tab[$urandom_range(0, 42)];
                else b = 8'($urandom);
                mem[i] = b; m[i] = b;
            end
            qa.delete(); qw.delete(); qd.delete();
            ma = 8'h00; mx = 8'h00; my = 8'h00; ms = 8'hFF; mp = 8'h24; mpc = 16'h8000;
            do_reset();
            bad = 1'b0;
            for (int cyc = 0; cyc < 3000 && !bad; cyc++) begin
                if (qa.size() == 0) begin
                    n_tests++;
                    if ({dut.a_q, dut.x_q, dut.y_q, dut.s_q, dut.p_q, dut.pc_q} !== {ma, mx, my, ms, mp, mpc}) begin
                        n_fail++; bad = 1'b1;
                        $display("FAIL rand_regs r%0d c%0d: got %h, want %h", round, cyc,
                                 {dut.a_q, dut.x_q, dut.y_q, dut.s_q, dut.p_q, dut.pc_q}, {ma, mx, my, ms, mp, mpc});
                    end
                    model_step();
                end
                ea = qa.pop_front(); ew = qw.pop_front(); ed = qd.pop_front();
                n_tests++;
                if (!bad && (adr !== ea || we !== ew || (ew && dout !== ed))) begin
                    n_fail++; bad = 1'b1;
                    $display("FAIL rand_bus r%0d c%0d: got adr=%h we=%b dout=%h, want %h %b %h",
                             round, cyc, adr, we, dout, ea, ew, ed);
                end
                tick();
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        irq = 1'b0; nmi = 1'b0; rdy = 1'b1;
        test_reset();
        test_init_seq();
        test_copy_loop();
        test_terminal_loop();
        test_compare_branch();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
